fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-operand, two-stage forwarding unit: resolves NSRC source operands against NFWD in-flight pipeline stages, nearest stage first.
- Adds load-use interlock through per-stage result-ready flags.
- Adds a sequential tracker for one multicycle functional unit (mul/div), with RAW/WAW/structural interlocks and a saturating stall-cycle counter.
- Sits beside the decode stage. Drives operand-mux selects into the datapath and the stall into the pipeline latch enables.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fwd_hazard_unit_if.sv | 39 +++
 rtl/fwd_select.sv | 57 +++++
 rtl/fwd_hazard_unit.sv | 130 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared register/FSM types for the forwarding and hazard unit
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam int FWD_REGFILE = 0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - signal bundle around fwd_hazard_unit (fu = unit side, tb = driver side)
interface fwd_hazard_unit_if #(
    parameter int NSRC = 2,
    parameter int NFWD = 3,
    parameter int CNTW = 16,
    localparam int SELW = $clog2(NFWD + 2)
) (
    input logic CLK
);
    logic                 nRST;
    logic                 id_valid;
    logic [NSRC*5-1:0]    id_rs;
    logic                 id_regwrite;
    logic [4:0]           id_wsel;
    logic                 id_mc;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD*5-1:0]    fwd_wsel;
    logic [NFWD-1:0]      fwd_rdy;
    logic                 mc_kill;
    logic                 cnt_clr;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 stall;
    logic                 mc_busy;
    logic                 mc_done;
    logic [4:0]           mc_wsel;
    logic [CNTW-1:0]      stall_count;

    modport fu (
        input  CLK, nRST, id_valid, id_rs, id_regwrite, id_wsel, id_mc,
               fwd_valid, fwd_wsel, fwd_rdy, mc_kill, cnt_clr,
        output fwd_sel, stall, mc_busy, mc_done, mc_wsel, stall_count
    );

    modport tb (
        input  CLK, fwd_sel, stall, mc_busy, mc_done, mc_wsel, stall_count,
        output nRST, id_valid, id_rs, id_regwrite, id_wsel, id_mc,
               fwd_valid, fwd_wsel, fwd_rdy, mc_kill, cnt_clr
    );
endinterface

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-source forwarding priority match
// Ports: i_rs source register; i_fwd_valid/i_fwd_wsel/i_fwd_rdy pipeline stage state;
//        i_mc_busy/i_mc_done/i_mc_wsel multicycle tracker state;
//        o_sel operand-mux select; o_hazard unready youngest match; o_raw pending multicycle result.
module fwd_select
    import cpu_types_pkg::*;
#(
    parameter int NFWD = 3,
    parameter int SELW = 3
) (
    input  regbits_t          i_rs,
    input  logic [NFWD-1:0]   i_fwd_valid,
    input  logic [NFWD*5-1:0] i_fwd_wsel,
    input  logic [NFWD-1:0]   i_fwd_rdy,
    input  logic              i_mc_busy,
    input  logic              i_mc_done,
    input  regbits_t          i_mc_wsel,
    output logic [SELW-1:0]   o_sel,
    output logic              o_hazard,
    output logic              o_raw
);
    logic            w_hit;
    logic            w_hit_rdy;
    logic [SELW-1:0] w_hit_sel;

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_rdy = 1'b0;
        w_hit_sel = SELW'(FWD_REGFILE);
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && (i_fwd_wsel[k*5 +: 5] == i_rs)) begin
                w_hit     = 1'b1;
                w_hit_rdy = i_fwd_rdy[k];
                w_hit_sel = SELW'(k + 1);
            end
        end
    end

    always_comb begin
        o_sel    = SELW'(FWD_REGFILE);
        o_hazard = 1'b0;
        o_raw    = 1'b0;
        if (i_rs != '0) begin
            if (w_hit) begin
                // An unready youngest producer must be waited for; older copies are stale.
                o_sel    = w_hit_sel;
                o_hazard = ~w_hit_rdy;
            end else begin
                if (i_mc_done && (i_mc_wsel == i_rs)) begin
                    o_sel = SELW'(NFWD + 1);
                end
                o_raw = i_mc_busy && (i_mc_wsel == i_rs);
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, load-use and multicycle interlocks beside decode
// Ports: CLK/nRST; id_* decode instruction; fwd_* pipeline stage state; mc_kill aborts the
//        multicycle op; cnt_clr clears stall_count; fwd_sel per-source mux selects; stall holds
//        decode; mc_busy/mc_done/mc_wsel multicycle tracker; stall_count saturating stall cycles.
module fwd_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int NFWD   = 3,
    parameter int MC_LAT = 4,
    parameter int CNTW   = 16,
    localparam int SELW  = $clog2(NFWD + 2)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 id_valid,
    input  logic [NSRC*5-1:0]    id_rs,
    input  logic                 id_regwrite,
    input  logic [4:0]           id_wsel,
    input  logic                 id_mc,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_wsel,
    input  logic [NFWD-1:0]      fwd_rdy,
    input  logic                 mc_kill,
    input  logic                 cnt_clr,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall,
    output logic                 mc_busy,
    output logic                 mc_done,
    output logic [4:0]           mc_wsel,
    output logic [CNTW-1:0]      stall_count
);
    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    mc_state_t       r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    regbits_t        r_mc_wsel, w_mc_wsel_nxt;
    logic [CNTW-1:0] r_stall_count;

    logic            w_is_busy, w_is_done;
    logic [NSRC-1:0] w_hazard, w_raw;
    logic            w_mc_waw, w_mc_struct, w_issue;

    assign w_is_busy = (r_state == BUSY);
    assign w_is_done = (r_state == DONE);

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_select #(
            .NFWD (NFWD),
            .SELW (SELW)
        ) u_sel (
            .i_rs        (id_rs[5*i +: 5]),
            .i_fwd_valid (fwd_valid),
            .i_fwd_wsel  (fwd_wsel),
            .i_fwd_rdy   (fwd_rdy),
            .i_mc_busy   (w_is_busy),
            .i_mc_done   (w_is_done),
            .i_mc_wsel   (r_mc_wsel),
            .o_sel       (fwd_sel[SELW*i +: SELW]),
            .o_hazard    (w_hazard[i]),
            .o_raw       (w_raw[i])
        );
    end

    assign w_mc_waw = id_regwrite && (w_is_busy || w_is_done)
                      && (id_wsel == r_mc_wsel) && (id_wsel != '0);
    // DONE accepts a back-to-back issue unless a kill is forcing the unit to IDLE.
    assign w_mc_struct = id_mc && (w_is_busy || (w_is_done && mc_kill));
    assign stall   = id_valid && ((|w_hazard) || (|w_raw) || w_mc_waw || w_mc_struct);
    assign w_issue = id_valid && id_mc && !stall;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_mc_wsel_nxt = r_mc_wsel;
        if (mc_kill) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    w_state_nxt = IDLE;
                    if (w_issue) begin
                        w_state_nxt   = BUSY;
                        w_cnt_nxt     = CW'(MC_LAT - 2);
                        w_mc_wsel_nxt = id_wsel;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mc_wsel <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mc_wsel <= w_mc_wsel_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_count <= '0;
        end else if (cnt_clr) begin
            r_stall_count <= '0;
        end else if (stall && (r_stall_count != {CNTW{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign mc_busy     = (r_state != IDLE);
    assign mc_done     = w_is_done;
    assign mc_wsel     = r_mc_wsel;
    assign stall_count = r_stall_count;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
    localparam int NSRC   = 2;
    localparam int NFWD   = 3;
    localparam int MC_LAT = 4;
    localparam int CNTW   = 16;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NSRC(NSRC), .NFWD(NFWD), .CNTW(CNTW)) bus (.CLK(clk));

    fwd_hazard_unit #(
        .NSRC(NSRC), .NFWD(NFWD), .MC_LAT(MC_LAT), .CNTW(CNTW)
    ) dut (
        .CLK         (clk),
        .nRST        (bus.nRST),
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_regwrite (bus.id_regwrite),
        .id_wsel     (bus.id_wsel),
        .id_mc       (bus.id_mc),
        .fwd_valid   (bus.fwd_valid),
        .fwd_wsel    (bus.fwd_wsel),
        .fwd_rdy     (bus.fwd_rdy),
        .mc_kill     (bus.mc_kill),
        .cnt_clr     (bus.cnt_clr),
        .fwd_sel     (bus.fwd_sel),
        .stall       (bus.stall),
        .mc_busy     (bus.mc_busy),
        .mc_done     (bus.mc_done),
        .mc_wsel     (bus.mc_wsel),
        .stall_count (bus.stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sel0();
        return 32'(bus.fwd_sel[2:0]);
    endfunction

    function automatic logic [31:0] sel1();
        return 32'(bus.fwd_sel[5:3]);
    endfunction

    initial begin
        bus.nRST        = 1'b0;
        bus.id_valid    = 1'b0;
        bus.id_rs       = '0;
        bus.id_regwrite = 1'b0;
        bus.id_wsel     = '0;
        bus.id_mc       = 1'b0;
        bus.fwd_valid   = '0;
        bus.fwd_wsel    = '0;
        bus.fwd_rdy     = '0;
        bus.mc_kill     = 1'b0;
        bus.cnt_clr     = 1'b0;
        #3;
        chk("rst_busy", 32'(bus.mc_busy), 32'd0);
        chk("rst_done", 32'(bus.mc_done), 32'd0);
        chk("rst_count", 32'(bus.stall_count), 32'd0);
        chk("rst_wsel", 32'(bus.mc_wsel), 32'd0);
        tick();
        bus.nRST = 1'b1;
        tick();

        // Youngest ready stage wins
        bus.id_valid  = 1'b1;
        bus.id_rs     = {5'd0, 5'd5};
        bus.fwd_valid = 3'b011;
        bus.fwd_wsel  = {5'd9, 5'd5, 5'd5};
        bus.fwd_rdy   = 3'b111;
        #1;
        chk("young_sel0", sel0(), 32'd1);
        chk("young_stall", 32'(bus.stall), 32'd0);

        // Load-use: youngest match not ready, older ready copy ignored
        bus.fwd_rdy = 3'b110;
        #1;
        chk("lu_stall", 32'(bus.stall), 32'd1);
        tick();
        tick();
        chk("lu_count2", 32'(bus.stall_count), 32'd2);
        bus.fwd_valid = 3'b010;
        #1;
        chk("lu_drop_sel0", sel0(), 32'd2);
        chk("lu_drop_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("lu_count_hold", 32'(bus.stall_count), 32'd2);

        // Register 0 never forwards; unmatched source reads regfile
        bus.id_rs     = {5'd0, 5'd5};
        bus.fwd_valid = 3'b001;
        bus.fwd_wsel  = {5'd9, 5'd9, 5'd0};
        bus.fwd_rdy   = 3'b000;
        #1;
        chk("r0_sel1", sel1(), 32'd0);
        chk("r0_sel0", sel0(), 32'd0);
        chk("r0_stall", 32'(bus.stall), 32'd0);

        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        chk("clr_count", 32'(bus.stall_count), 32'd0);

        // Multicycle issue at t, wsel 7
        bus.fwd_valid   = '0;
        bus.id_rs       = '0;
        bus.id_mc       = 1'b1;
        bus.id_regwrite = 1'b1;
        bus.id_wsel     = 5'd7;
        #1;
        chk("t0_stall", 32'(bus.stall), 32'd0);
        tick();  // t+1
        bus.id_mc       = 1'b0;
        bus.id_regwrite = 1'b0;
        bus.id_rs       = {5'd0, 5'd7};
        #1;
        chk("t1_busy", 32'(bus.mc_busy), 32'd1);
        chk("t1_raw_stall", 32'(bus.stall), 32'd1);
        chk("t1_mc_wsel", 32'(bus.mc_wsel), 32'd7);
        tick();  // t+2
        bus.id_mc   = 1'b1;
        bus.id_wsel = 5'd8;
        bus.id_rs   = '0;
        #1;
        chk("t2_struct_stall", 32'(bus.stall), 32'd1);
        tick();  // t+3
        bus.id_rs = {5'd0, 5'd7};
        #1;
        chk("t3_busy", 32'(bus.mc_busy), 32'd1);
        chk("t3_done", 32'(bus.mc_done), 32'd0);
        chk("t3_stall", 32'(bus.stall), 32'd1);
        tick();  // t+4
        chk("t4_done", 32'(bus.mc_done), 32'd1);
        chk("t4_sel0_mc", sel0(), 32'(NFWD + 1));
        chk("t4_stall", 32'(bus.stall), 32'd0);
        tick();  // t+5: second op (wsel 8) now busy
        bus.id_mc = 1'b0;
        bus.id_rs = '0;
        #1;
        chk("t5_busy", 32'(bus.mc_busy), 32'd1);
        chk("t5_done", 32'(bus.mc_done), 32'd0);
        chk("t5_wsel", 32'(bus.mc_wsel), 32'd8);

        // WAW against the in-flight destination; r0 exempt
        bus.id_regwrite = 1'b1;
        #1;
        chk("waw_stall", 32'(bus.stall), 32'd1);
        bus.id_wsel = 5'd0;
        #1;
        chk("waw_r0_stall", 32'(bus.stall), 32'd0);
        bus.id_regwrite = 1'b0;

        tick();  // t+6
        tick();  // t+7
        tick();  // t+8: DONE for the second op
        bus.id_mc   = 1'b1;
        bus.id_wsel = 5'd9;
        bus.mc_kill = 1'b1;
        #1;
        chk("kd_done", 32'(bus.mc_done), 32'd1);
        chk("kd_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.mc_kill = 1'b0;
        bus.id_mc   = 1'b0;
        #1;
        chk("kd_idle", 32'(bus.mc_busy), 32'd0);

        // Kill mid-BUSY
        bus.id_mc   = 1'b1;
        bus.id_wsel = 5'd7;
        tick();  // t+1
        bus.id_mc = 1'b0;
        tick();  // t+2
        bus.mc_kill = 1'b1;
        bus.id_rs   = {5'd0, 5'd7};
        #1;
        chk("k2_stall", 32'(bus.stall), 32'd1);
        tick();  // t+3
        bus.mc_kill = 1'b0;
        #1;
        chk("k3_busy", 32'(bus.mc_busy), 32'd0);
        chk("k3_stall", 32'(bus.stall), 32'd0);
        chk("k3_sel0", sel0(), 32'd0);
        tick();  // t+4
        chk("k4_done", 32'(bus.mc_done), 32'd0);

        // Asynchronous reset while BUSY
        bus.id_rs   = '0;
        bus.id_mc   = 1'b1;
        bus.id_wsel = 5'd3;
        tick();
        bus.id_mc = 1'b0;
        chk("ar_busy_pre", 32'(bus.mc_busy), 32'd1);
        #2;
        bus.nRST = 1'b0;
        #1;
        chk("ar_busy", 32'(bus.mc_busy), 32'd0);
        chk("ar_wsel", 32'(bus.mc_wsel), 32'd0);
        tick();
        bus.nRST = 1'b1;

        // Saturation
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr   = 1'b0;
        bus.id_rs     = {5'd0, 5'd5};
        bus.fwd_valid = 3'b001;
        bus.fwd_wsel  = {5'd0, 5'd0, 5'd5};
        bus.fwd_rdy   = 3'b000;
        repeat ((1 << CNTW) + 3) tick();
        chk("sat_count", 32'(bus.stall_count), 32'h0000_FFFF);
        bus.cnt_clr = 1'b1;
        tick();
        chk("sat_clr", 32'(bus.stall_count), 32'd0);
        bus.cnt_clr = 1'b0;
        tick();
        chk("sat_restart", 32'(bus.stall_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
